imem_uart_loader: RTL
=====================

Name: imem_uart_loader

Overview:
- Writer side of the instruction-memory interface: receives a program over a UART serial line and writes it word-by-word into instruction memory port A.
- Holds the processor datapath in reset (cpu_hold) until the whole image is written, then releases it.
- Sits beside data_path at board top level, driven by the same undivided board clock.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); benches use 4.
ADDR_W, 8, instruction-memory word-address width.
DEPTH, 256, number of writable words (must be <= 2**ADDR_W).

Ports:
clk  input  1  board clock; the only clock.
rst  input  1  asynchronous, active-low reset.
uart_rx  input  1  serial line, idle high, 8N1, LSB first.
imem_we  output  1  one-cycle write strobe to instruction memory.
imem_addr  output  ADDR_W  word address for the write.
imem_wdata  output  32  word to write.
cpu_hold  output  1  high = keep datapath in reset.
load_done  output  1  high once the image is fully loaded.
frame_err  output  1  sticky: stop bit sampled low.
overflow  output  1  sticky: image longer than DEPTH.

Behaviour:
- Reset (rst=0, asynchronous): imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, load_done=0, frame_err=0, overflow=0, sync flops=1, both FSMs to their first state. Reset mid-load restarts the protocol; memory contents are not cleared.
- uart_rx passes through a 2-flop synchronizer before use.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE -> START on synchronized falling edge.
  - START: at CLKS_PER_BIT/2, line low -> DATA; line high -> IDLE (glitch rejected, no byte).
  - DATA: sample every CLKS_PER_BIT cycles from the start-bit mid-point; 8 bits, LSB first.
  - STOP: sample after a further CLKS_PER_BIT. High -> byte_valid pulses 1 cycle with the byte. Low -> set frame_err, drop the byte. Either case -> IDLE.
- Loader FSM (CNT_LO, CNT_HI, LOAD, DONE), advances only on byte_valid:
  - CNT_LO/CNT_HI capture a 16-bit word count, little-endian.
  - Count 0: DONE in the cycle after the CNT_HI byte.
  - LOAD assembles 4 bytes little-endian (first byte = bits 7:0).
  - The cycle after the 4th byte's byte_valid: imem_we=1 for exactly one cycle, imem_addr=word_idx[ADDR_W-1:0], imem_wdata=assembled word; word_idx then increments.
  - word_idx >= DEPTH: the write is suppressed (imem_we stays 0), overflow is set, and the word still counts.
  - When word_idx reaches count, go to DONE on the next cycle.
- DONE: load_done=1 and cpu_hold=0, both registered; all further bytes are ignored until reset.
- imem_addr and imem_wdata hold their last values between strobes.
- frame_err and overflow clear only on reset. A frame error does not abort the load; the host must reset and resend.
- Each byte takes at least 10*CLKS_PER_BIT cycles, so byte_valid and imem_we can never collide.

Decomposition:
- Shared package: RX state encoding, loader state encoding, UART_DATA_BITS=8, BYTES_PER_WORD=4.
- One natural sub-module: uart_rx_byte, containing the synchronizer, RX FSM and bit counters; outputs rx_byte[7:0], byte_valid, frame_err_pulse.
- The loader FSM, word assembly and address counter stay in imem_uart_loader.

Test Plan:
- CLKS_PER_BIT=4. Send count 02 00, then bytes 13 00 22 20 and 05 00 01 8C -> imem_we pulses twice: addr 0 data 0x20220013, addr 1 data 0x8C010005; then load_done=1, cpu_hold=0.
- Send count 00 00 -> load_done=1 the cycle after the 2nd byte_valid; imem_we never asserts.
- Low pulse of 1 clock on idle uart_rx -> no byte_valid, FSM back in IDLE; a following valid byte is received correctly.
- Byte 0xA5 with stop bit driven low -> frame_err=1 and stays set; byte_valid stays 0.
- DEPTH=2, count 3, twelve bytes -> writes to addr 0 and 1 only; overflow=1; load_done=1 after the 3rd word.
- Assert rst after 5 of 8 image bytes, release, resend the full image -> cpu_hold=1 during the resend; all words written from addr 0; load_done=1 at the end.

Source files
------------

// File: rtl/imem_uart_loader_pkg.sv
// Shared encodings and constants for the UART instruction-memory loader.
// Both FSM state types live here so the RX sub-module and the top agree on them.
package imem_uart_loader_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    LD_CNT_LO = 2'd0,
    LD_CNT_HI = 2'd1,
    LD_LOAD   = 2'd2,
    LD_DONE   = 2'd3
  } ld_state_e;

  // Little-endian byte lane insert: lane 0 is bits 7:0.
  function automatic logic [31:0] insert_byte(
    input logic [31:0] word,
    input logic [1:0]  lane,
    input logic [7:0]  data
  );
    logic [31:0] result;
    result = word;
    result[8*lane +: 8] = data;
    return result;
  endfunction

endpackage

// File: rtl/imem_uart_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling FSM,
// one-cycle byte_valid on a good stop bit, frame_err_pulse on a bad one.
module uart_rx_byte
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_rx_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err_pulse
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF_M1 = (CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0;
  localparam int FULL_M1 = CLKS_PER_BIT - 1;

  rx_state_e r_state;
  rx_state_e w_state_next;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_rx_prev;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic             r_frame_err_pulse;

  logic w_rx;
  logic w_fall;
  logic w_tick;
  logic w_last_bit;

  assign w_rx   = r_sync2;
  assign w_fall = r_rx_prev & ~w_rx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_state_next = RX_START;
      RX_START: if (w_tick) w_state_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick && w_last_bit) w_state_next = RX_STOP;
      RX_STOP:  if (w_tick) w_state_next = RX_IDLE;
      default:  w_state_next = RX_IDLE;
    endcase
  end

  // Start bit is checked at its mid-point; every later sample is one full bit on.
  always_comb begin
    w_tick     = 1'b0;
    w_last_bit = (r_bit_idx == 3'(UART_DATA_BITS - 1));
    case (r_state)
      RX_START: w_tick = (r_clk_cnt == CNT_W'(HALF_M1));
      RX_DATA,
      RX_STOP:  w_tick = (r_clk_cnt == CNT_W'(FULL_M1));
      default:  w_tick = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1           <= 1'b1;
      r_sync2           <= 1'b1;
      r_rx_prev         <= 1'b1;
      r_clk_cnt         <= '0;
      r_bit_idx         <= '0;
      r_shift           <= '0;
      r_byte_valid      <= 1'b0;
      r_frame_err_pulse <= 1'b0;
    end else begin
      r_sync1           <= i_rx;
      r_sync2           <= r_sync1;
      r_rx_prev         <= w_rx;
      r_byte_valid      <= 1'b0;
      r_frame_err_pulse <= 1'b0;

      if (r_state == RX_IDLE || w_tick || (w_state_next != r_state)) begin
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end

      if (r_state == RX_START && w_tick) begin
        r_bit_idx <= '0;
      end

      if (r_state == RX_DATA && w_tick) begin
        r_shift   <= {w_rx, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 1'b1;
      end

      if (r_state == RX_STOP && w_tick) begin
        if (w_rx) begin
          r_byte_valid <= 1'b1;
        end else begin
          r_frame_err_pulse <= 1'b1;
        end
      end
    end
  end

  assign o_rx_byte         = r_shift;
  assign o_byte_valid      = r_byte_valid;
  assign o_frame_err_pulse = r_frame_err_pulse;

endmodule

// File: rtl/imem_uart_loader.sv
// Receives a length-prefixed program over UART and writes it into instruction
// memory port A, holding the CPU in reset until the whole image has landed.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_uart_rx,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_hold,
  output logic              o_load_done,
  output logic              o_frame_err,
  output logic              o_overflow
);

  ld_state_e r_state;
  ld_state_e w_state_next;

  logic [15:0]       r_count;
  logic [16:0]       r_word_idx;
  logic [1:0]        r_byte_idx;
  logic [31:0]       r_word;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_cpu_hold;
  logic              r_load_done;
  logic              r_frame_err;
  logic              r_overflow;

  logic [7:0] w_rx_byte;
  logic       w_byte_valid;
  logic       w_frame_err_pulse;
  logic       w_word_full;
  logic       w_in_range;
  logic       w_we_next;
  logic       w_ovf_set;
  logic       w_enter_done;
  logic       w_count_zero;
  logic       w_all_words;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_rx              (i_uart_rx),
    .o_rx_byte         (w_rx_byte),
    .o_byte_valid      (w_byte_valid),
    .o_frame_err_pulse (w_frame_err_pulse)
  );

  assign w_count_zero = ({w_rx_byte, r_count[7:0]} == 16'd0);
  assign w_all_words  = (r_word_idx == {1'b0, r_count});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= LD_CNT_LO;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LD_CNT_LO: if (w_byte_valid) w_state_next = LD_CNT_HI;
      LD_CNT_HI: if (w_byte_valid) w_state_next = w_count_zero ? LD_DONE : LD_LOAD;
      // The last write strobe has just gone out when the index catches the count.
      LD_LOAD:   if (!w_byte_valid && w_all_words) w_state_next = LD_DONE;
      LD_DONE:   w_state_next = LD_DONE;
      default:   w_state_next = LD_CNT_LO;
    endcase
  end

  always_comb begin
    w_word_full  = w_byte_valid && (r_state == LD_LOAD) &&
                   (r_byte_idx == 2'(BYTES_PER_WORD - 1));
    w_in_range   = (r_word_idx < 17'(DEPTH));
    w_we_next    = w_word_full && w_in_range;
    w_ovf_set    = w_word_full && !w_in_range;
    w_enter_done = (w_state_next == LD_DONE) && (r_state != LD_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count      <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_hold   <= 1'b1;
      r_load_done  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_imem_we <= w_we_next;

      if (w_frame_err_pulse) r_frame_err <= 1'b1;
      if (w_ovf_set)         r_overflow  <= 1'b1;

      if (w_byte_valid && r_state == LD_CNT_LO) r_count[7:0]  <= w_rx_byte;
      if (w_byte_valid && r_state == LD_CNT_HI) r_count[15:8] <= w_rx_byte;

      if (w_byte_valid && r_state == LD_LOAD) begin
        r_word     <= insert_byte(r_word, r_byte_idx, w_rx_byte);
        r_byte_idx <= r_byte_idx + 1'b1;
      end

      // Out-of-range words are dropped but still advance the index toward the count.
      if (w_word_full) begin
        r_word_idx <= r_word_idx + 1'b1;
      end

      if (w_we_next) begin
        r_imem_addr  <= r_word_idx[ADDR_W-1:0];
        r_imem_wdata <= insert_byte(r_word, r_byte_idx, w_rx_byte);
      end

      if (w_enter_done) begin
        r_load_done <= 1'b1;
        r_cpu_hold  <= 1'b0;
      end
    end
  end

  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_load_done  = r_load_done;
  assign o_frame_err  = r_frame_err;
  assign o_overflow   = r_overflow;

endmodule
